// File: rtl/z16_mmio_pkg.sv
// z16_mmio_pkg: MMIO address map, LED width and address decode shared by the z16 I/O block.
package z16_mmio_pkg;
   localparam logic [15:0] ADDR_LED   = 16'h007A;
   localparam logic [15:0] ADDR_BTN   = 16'h007C;
   localparam logic [15:0] ADDR_TIMER = 16'h007E;
   localparam int LED_W = 6;
   typedef enum logic [1:0] {SEL_NONE, SEL_LED, SEL_BTN, SEL_TIMER} sel_e;
   function automatic sel_e decode(input logic [15:0] addr);
      return addr == ADDR_LED ? SEL_LED :
             addr == ADDR_BTN ? SEL_BTN :
             addr == ADDR_TIMER ? SEL_TIMER : SEL_NONE;
   endfunction
endpackage

// File: rtl/z16_debounce.sv
// z16_debounce: 2-flop synchronizer plus consecutive-sample debouncer for the board button.
module z16_debounce #(
   parameter int DEBOUNCE_CYCLES = 270000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   logic [1:0] sync;
   logic [CW-1:0] cnt;
   logic diff, done;
   assign diff = sync[1] ^ o_level;
   assign done = diff && cnt == CW'(DEBOUNCE_CYCLES - 1);
   // high during the cycle whose closing edge raises o_level
   assign o_rise = done & ~o_level;
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync    <= '0;
         cnt     <= '0;
         o_level <= 1'b0;
      end else begin
         sync <= {sync[0], i_raw};
         cnt  <= (diff && !done) ? cnt + CW'(1) : '0;
         if (done) o_level <= ~o_level;
      end
   end
endmodule

// File: rtl/z16_mmio_io.sv
// z16_mmio_io: memory-mapped LED register, debounced button with sticky press flag,
// and free-running prescaled 16-bit timer for the z16 CPU data bus.
module z16_mmio_io
   import z16_mmio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int TICK_DIV        = 27000
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [15:0]      i_addr,
   input  logic             i_we,
   input  logic             i_re,
   input  logic [15:0]      i_wdata,
   input  logic             i_button,
   output logic [15:0]      o_rdata,
   output logic             o_hit,
   output logic [LED_W-1:0] o_led
);
   localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   sel_e sel;
   logic btn_level, btn_rise, press_flag, tc;
   logic [PW-1:0] pre;
   logic [15:0] timer;
   z16_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_raw  (i_button),
      .o_level(btn_level),
      .o_rise (btn_rise)
   );
   assign sel     = decode(i_addr);
   assign o_hit   = sel != SEL_NONE;
   assign o_rdata = sel == SEL_LED   ? {{(16-LED_W){1'b0}}, o_led} :
                    sel == SEL_BTN   ? {14'b0, press_flag, btn_level} :
                    sel == SEL_TIMER ? timer : 16'h0000;
   assign tc      = pre == PW'(TICK_DIV - 1);
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_led      <= '0;
         press_flag <= 1'b0;
         pre        <= '0;
         timer      <= 16'h0000;
      end else begin
         if (i_we && sel == SEL_LED) o_led <= i_wdata[LED_W-1:0];
         // a new press wins over a coincident read-clear
         press_flag <= btn_rise | (press_flag & ~(i_re && sel == SEL_BTN));
         if (i_we && sel == SEL_TIMER) begin
            timer <= i_wdata;
            pre   <= '0;
         end else begin
            pre   <= tc ? '0 : pre + PW'(1);
            timer <= timer + 16'(tc);
         end
      end
   end
endmodule

// File: tb/tb_z16_mmio_io.sv
// tb_z16_mmio_io: directed vector table plus hand-written multi-cycle sequences (DEBOUNCE_CYCLES=4, TICK_DIV=3).
module tb_z16_mmio_io;
   logic clk = 1'b0, rst = 1'b1, we = 1'b0, re = 1'b0, button = 1'b0;
   logic [15:0] addr = 16'h0000, wdata = 16'h0000, rdata;
   logic hit;
   logic [5:0] led;
   int n_chk = 0, n_fail = 0;

   typedef struct {
      logic        we, re;
      logic [15:0] addr, wdata;
      logic        chk;
      logic [15:0] rdata;
      logic        hit;
      logic [5:0]  led;
   } vec_t;
   vec_t tv[15];

   z16_mmio_io #(.DEBOUNCE_CYCLES(4), .TICK_DIV(3)) dut (
      .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_we(we), .i_re(re),
      .i_wdata(wdata), .i_button(button), .o_rdata(rdata), .o_hit(hit), .o_led(led)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic r, input logic [15:0] a, input logic [15:0] d);
      we = w; re = r; addr = a; wdata = d;
      #1;
   endtask

   initial begin
      tv[0]  = '{1'b1, 1'b0, 16'h007A, 16'h002D, 1'b1, 16'h0000, 1'b1, 6'h00};
      tv[1]  = '{1'b0, 1'b1, 16'h007A, 16'h0000, 1'b1, 16'h002D, 1'b1, 6'h2D};
      tv[2]  = '{1'b0, 1'b1, 16'h0050, 16'h0000, 1'b1, 16'h0000, 1'b0, 6'h2D};
      tv[3]  = '{1'b1, 1'b0, 16'h007C, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 6'h2D};
      tv[4]  = '{1'b0, 1'b1, 16'h007C, 16'h0000, 1'b1, 16'h0000, 1'b1, 6'h2D};
      tv[5]  = '{1'b1, 1'b0, 16'h007E, 16'hFFFE, 1'b0, 16'h0000, 1'b1, 6'h2D};
      tv[6]  = '{1'b0, 1'b1, 16'h007E, 16'h0000, 1'b1, 16'hFFFE, 1'b1, 6'h2D};
      tv[7]  = '{1'b0, 1'b1, 16'h007E, 16'h0000, 1'b1, 16'hFFFE, 1'b1, 6'h2D};
      tv[8]  = '{1'b0, 1'b1, 16'h007E, 16'h0000, 1'b1, 16'hFFFE, 1'b1, 6'h2D};
      tv[9]  = '{1'b0, 1'b1, 16'h007E, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 6'h2D};
      tv[10] = '{1'b0, 1'b1, 16'h007E, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 6'h2D};
      tv[11] = '{1'b0, 1'b1, 16'h007E, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 6'h2D};
      tv[12] = '{1'b0, 1'b1, 16'h007E, 16'h0000, 1'b1, 16'h0000, 1'b1, 6'h2D};
      tv[13] = '{1'b1, 1'b0, 16'h007A, 16'hFFC0, 1'b1, 16'h002D, 1'b1, 6'h2D};
      tv[14] = '{1'b0, 1'b1, 16'h007A, 16'h0000, 1'b1, 16'h0000, 1'b1, 6'h00};

      // reset state, visible combinationally while reset is held
      drive(0, 0, 16'h007C, 0);
      chk("rst_btn", rdata, 16'h0000);
      chk("rst_led", {10'b0, led}, 16'h0000);
      drive(0, 0, 16'h007E, 0);
      chk("rst_timer", rdata, 16'h0000);
      step();
      step();
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         drive(tv[i].we, tv[i].re, tv[i].addr, tv[i].wdata);
         if (tv[i].chk) chk($sformatf("vec%0d_rdata", i), rdata, tv[i].rdata);
         chk($sformatf("vec%0d_hit", i), {15'b0, hit}, {15'b0, tv[i].hit});
         chk($sformatf("vec%0d_led", i), {10'b0, led}, {10'b0, tv[i].led});
         step();
      end

      // clean press: level rises on the 6th edge, flag read then cleared
      button = 1'b1;
      drive(0, 0, 16'h007C, 0);
      for (int i = 1; i <= 6; i++) begin
         step();
         chk($sformatf("press_edge%0d", i), rdata, i == 6 ? 16'h0003 : 16'h0000);
      end
      drive(0, 1, 16'h007C, 0);
      chk("press_read_pre_clear", rdata, 16'h0003);
      step();
      chk("press_read_post_clear", rdata, 16'h0001);
      drive(0, 0, 16'h007C, 0);
      step();
      chk("press_flag_stays_clear", rdata, 16'h0001);

      // clean release
      button = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         step();
         chk($sformatf("release_edge%0d", i), rdata, i == 6 ? 16'h0000 : 16'h0001);
      end

      // 3-clock glitch must not change the level
      button = 1'b1;
      for (int i = 1; i <= 3; i++) step();
      button = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         step();
         chk($sformatf("glitch_edge%0d", i), rdata, 16'h0000);
      end

      // read-clear in the same cycle the level rises: set wins
      button = 1'b1;
      for (int i = 1; i <= 5; i++) step();
      drive(0, 1, 16'h007C, 0);
      chk("collide_pre", rdata, 16'h0000);
      step();
      drive(0, 0, 16'h007C, 0);
      chk("collide_flag_set", rdata, 16'h0003);
      drive(0, 1, 16'h007C, 0);
      step();
      drive(0, 0, 16'h007C, 0);
      chk("collide_then_clear", rdata, 16'h0001);

      // store and load together at the timer address
      drive(1, 1, 16'h007E, 16'h1234);
      step();
      drive(0, 0, 16'h007E, 0);
      chk("timer_we_re", rdata, 16'h1234);

      // reset mid-debounce with all LEDs lit
      button = 1'b0;
      drive(0, 0, 16'h007C, 0);
      for (int i = 1; i <= 6; i++) step();
      chk("pre_rst_released", rdata, 16'h0000);
      drive(1, 0, 16'h007A, 16'h003F);
      step();
      drive(0, 0, 16'h007A, 0);
      chk("led_3f", {10'b0, led}, 16'h003F);
      button = 1'b1;
      drive(0, 0, 16'h007C, 0);
      for (int i = 1; i <= 4; i++) step();
      rst = 1'b1;
      #1;
      chk("midrst_led", {10'b0, led}, 16'h0000);
      chk("midrst_btn", rdata, 16'h0000);
      addr = 16'h007E;
      #1;
      chk("midrst_timer", rdata, 16'h0000);
      rst = 1'b0;
      addr = 16'h007C;
      for (int i = 1; i <= 6; i++) begin
         step();
         chk($sformatf("postrst_edge%0d", i), rdata, i == 6 ? 16'h0003 : 16'h0000);
      end
      drive(0, 0, 16'h007E, 0);
      chk("postrst_timer", rdata, 16'h0002);
      drive(0, 0, 16'h0050, 0);
      chk("unmapped_rdata", rdata, 16'h0000);
      chk("unmapped_hit", {15'b0, hit}, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/z16_mmio_io.md
Z16_MMIO_IO -- requirements
Module: z16_mmio_io

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 270000, meaning consecutive stable synchronized samples required to accept a button change (minimum 2).
REQ-002 SHALL have parameter TICK_DIV, default 27000, meaning clock cycles per timer increment (minimum 1).
REQ-003 SHALL have port i_clk  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_addr  input  16  CPU data address, the ALU result.
REQ-006 SHALL have port i_we  input  1  store strobe for the current cycle.
REQ-007 SHALL have port i_re  input  1  load strobe for the current cycle.
REQ-008 SHALL have port i_wdata  input  16  store data, the rs2 value.
REQ-009 SHALL have port i_button  input  1  raw asynchronous board button.
REQ-010 SHALL have port o_rdata  output  16  combinational read data for i_addr.
REQ-011 SHALL have port o_hit  output  1  combinational; high when i_addr is a mapped MMIO address.
REQ-012 SHALL have port o_led  output  6  registered LED drive.

Function
REQ-013 SHALL map three addresses: LED 0x007A, BTN 0x007C, TIMER 0x007E; o_hit=1 only for these, else o_rdata=0x0000 and writes ignored.
REQ-014 LED: i_we at 0x007A SHALL load o_led<=i_wdata[5:0] at that edge; read returns {10'b0,o_led}.
REQ-015 BTN read SHALL return {14'b0, press_flag, btn_level}; writes to 0x007C ignored.
REQ-016 i_button SHALL pass a 2-flop synchronizer before any other use.
REQ-017 Debounce: counter increments each cycle synced!=btn_level, clears when equal; on reaching DEBOUNCE_CYCLES consecutive mismatches btn_level SHALL toggle and counter clear.
REQ-018 Latency: a clean input step SHALL appear on btn_level exactly 2+DEBOUNCE_CYCLES clocks after the first sampling edge.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change btn_level.
REQ-020 press_flag SHALL set at the edge where btn_level goes 0->1, and remain set until cleared.
REQ-021 i_re with i_addr=0x007C SHALL clear press_flag at that edge; o_rdata that cycle shows the pre-clear value.
REQ-022 Simultaneous set and clear of press_flag: set SHALL win (flag=1).
REQ-023 Timer: prescaler counts 0..TICK_DIV-1; at terminal count it wraps to 0 and timer increments by 1, 0xFFFF wrapping to 0x0000.
REQ-024 i_we at 0x007E SHALL load timer<=i_wdata and prescaler<=0; load overrides a coincident increment.
REQ-025 TIMER read returns the current 16-bit timer value.
REQ-026 i_we and i_re together at the same address: store effect and read side-effect SHALL both apply.

Reset
REQ-027 i_rst SHALL asynchronously force o_led=0, btn_level=0, press_flag=0, synchronizer=0, debounce counter=0, prescaler=0, timer=0x0000.
REQ-028 Reset mid-debounce or mid-prescale SHALL discard partial counts; counting restarts from 0 after release.
REQ-029 Combinational outputs during reset SHALL reflect reset state (BTN reads 0x0000, TIMER reads 0x0000).

Structure
REQ-030 Shared package z16_mmio_pkg SHALL hold ADDR_LED, ADDR_BTN, ADDR_TIMER constants and LED width 6.
REQ-031 Synchronizer plus debounce SHALL be one sub-module z16_debounce (ports i_clk, i_rst, i_raw, o_level, o_rise).
REQ-032 Counter widths SHALL be derived via $clog2 of the parameters; no fixed-width truncation.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=3)
REQ-033 Store 0x002D to 0x007A -> o_led=6'h2D next edge; load 0x007A -> o_rdata=0x002D, o_hit=1.
REQ-034 i_button 0->1 held -> btn_level=1 after exactly 6 clocks, press_flag=1; load 0x007C -> 0x0003, next load -> 0x0001.
REQ-035 i_button 3-clock pulse -> btn_level stays 0, press_flag stays 0, BTN reads 0x0000.
REQ-036 Store 0xFFFE to 0x007E -> reads 0xFFFE, 0xFFFF after 3 clocks, 0x0000 after 6 clocks.
REQ-037 Read-clear of 0x007C in the same cycle btn_level rises -> press_flag=1 afterwards.
REQ-038 Assert i_rst mid-debounce and with o_led=0x3F -> all outputs 0 immediately; after release, 4 stable cycles re-required; load 0x0050 -> o_hit=0, o_rdata=0.
